// File: rtl/write_buffer_pkg.sv
// Shared definitions for the cache-line write buffer: geometry, state encodings
// and the stored entry layout.
package write_buffer_pkg;

    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 128;
    localparam int OFFSET_W = 4;
    localparam int LINE_W   = ADDR_W - OFFSET_W;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [1:0] WB_EMPTY   = 2'b00;
    localparam logic [1:0] WB_WORKING = 2'b01;
    localparam logic [1:0] WB_FULL    = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] line;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Occupancy to externally visible state; 2'b10 is never produced.
    function automatic logic [1:0] state_of(input logic [CNT_W-1:0] cnt);
        if (cnt == '0)
            return WB_EMPTY;
        else if (cnt == CNT_W'(DEPTH))
            return WB_FULL;
        else
            return WB_WORKING;
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side request/response and AXI write-side signals of the write buffer.
interface write_buffer_if;
    import write_buffer_pkg::*;

    logic              wreq_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              whit_o;
    logic              rreq_i;
    logic [ADDR_W-1:0] raddr_i;
    logic              rhit_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        state_o;
    logic              AXI_valid_i;
    logic              AXI_wen_o;
    logic [DATA_W-1:0] AXI_wdata_o;
    logic [ADDR_W-1:0] AXI_waddr_o;

    // Driver side (data cache plus AXI responder).
    modport master (
        output wreq_i, waddr_i, wdata_i, rreq_i, raddr_i, AXI_valid_i,
        input  whit_o, rhit_o, rdata_o, state_o, AXI_wen_o, AXI_wdata_o, AXI_waddr_o
    );

    // The write buffer itself.
    modport slave (
        input  wreq_i, waddr_i, wdata_i, rreq_i, raddr_i, AXI_valid_i,
        output whit_o, rhit_o, rdata_o, state_o, AXI_wen_o, AXI_wdata_o, AXI_waddr_o
    );

endinterface

// File: rtl/write_buffer.sv
// Circular write buffer of dirty cache lines. Oldest entry is presented to AXI
// and popped on write response; writes to an already queued line merge in place
// and reads that hit a queued line return its data.
module write_buffer
    import write_buffer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    write_buffer_if.slave bus
);

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rline;
    logic [DEPTH-1:0]  wmatch;
    logic [DEPTH-1:0]  rmatch;
    logic [PTR_W-1:0]  widx;
    logic [DATA_W-1:0] rdata_sel;
    logic              w_hit;
    logic              head_hit;
    logic              not_empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              unused_offsets;

    assign wline          = bus.waddr_i[ADDR_W-1:OFFSET_W];
    assign rline          = bus.raddr_i[ADDR_W-1:OFFSET_W];
    assign unused_offsets = ^{bus.waddr_i[OFFSET_W-1:0], bus.raddr_i[OFFSET_W-1:0]};

    // Tag compare of both request addresses against every valid entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cam
        assign wmatch[i] = entries[i].valid && (entries[i].line == wline);
        assign rmatch[i] = entries[i].valid && (entries[i].line == rline);
    end

    // Encode the (at most one) matching slot for writes and select read data.
    always_comb begin
        widx      = '0;
        rdata_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wmatch[i]) widx = PTR_W'(i);
            if (rmatch[i]) rdata_sel = entries[i].data;
        end
    end

    // A merge into the head holds it so the fresh data is re-issued to AXI.
    assign not_empty  = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign w_hit      = bus.wreq_i && (|wmatch);
    assign head_hit   = w_hit && (widx == head);
    assign pop        = bus.AXI_valid_i && not_empty && !head_hit;
    assign push       = bus.wreq_i && !(|wmatch) && (!full || pop);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Head entry drives the AXI write request; zeros when nothing is queued.
    assign bus.AXI_wen_o   = not_empty;
    assign bus.AXI_waddr_o = not_empty ? {entries[head].line, {OFFSET_W{1'b0}}} : '0;
    assign bus.AXI_wdata_o = not_empty ? entries[head].data : '0;

    // Queue storage, pointers, occupancy and registered request responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            bus.state_o <= WB_EMPTY;
            bus.whit_o  <= 1'b0;
            bus.rhit_o  <= 1'b0;
            bus.rdata_o <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            // A push into a full buffer lands in the slot being popped, so it
            // must be ordered after the invalidate above.
            if (push) begin
                entries[tail] <= '{valid: 1'b1, line: wline, data: bus.wdata_i};
                tail          <= tail + PTR_W'(1);
            end
            if (w_hit) entries[widx].data <= bus.wdata_i;
            count       <= count_next;
            bus.state_o <= state_of(count_next);
            if (bus.wreq_i) bus.whit_o <= |wmatch;
            if (bus.rreq_i) begin
                bus.rhit_o  <= |rmatch;
                bus.rdata_o <= rdata_sel;
            end
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for the cache-line write buffer.
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam logic [127:0] D1 = 128'h34567891_02345678_91023456_78910234;
    localparam logic [127:0] DA = 128'h32345678_91023456_34567891_02345678;
    localparam logic [127:0] DB = 128'h12345678_91023456_78910234_56789102;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    write_buffer_if bus();

    write_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given request pulses; returns 1 ns after the edge.
    task automatic cycle(input logic wr, input logic [31:0] wa, input logic [127:0] wd,
                         input logic rd, input logic [31:0] ra, input logic av);
        @(negedge clk);
        bus.wreq_i      = wr;
        bus.waddr_i     = wa;
        bus.wdata_i     = wd;
        bus.rreq_i      = rd;
        bus.raddr_i     = ra;
        bus.AXI_valid_i = av;
        @(posedge clk);
        #1;
        bus.wreq_i      = 1'b0;
        bus.rreq_i      = 1'b0;
        bus.AXI_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d);
        cycle(1'b1, a, d, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b0, 32'h0, 128'h0, 1'b1, a, 1'b0);
    endtask

    task automatic ack();
        cycle(1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        bus.wreq_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
        bus.rreq_i = 1'b0; bus.raddr_i = '0; bus.AXI_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'(bus.state_o), 128'(WB_EMPTY));
        check("reset_wen",   128'(bus.AXI_wen_o), 128'd0);
        check("reset_waddr", 128'(bus.AXI_waddr_o), 128'd0);
        check("reset_wdata", bus.AXI_wdata_o, 128'd0);
        check("reset_whit",  128'(bus.whit_o), 128'd0);
        check("reset_rhit",  128'(bus.rhit_o), 128'd0);
        check("reset_rdata", bus.rdata_o, 128'd0);
        rst = 1'b1;

        // Response while empty must be ignored.
        ack();
        check("empty_ack_state", 128'(bus.state_o), 128'(WB_EMPTY));
        check("empty_ack_wen",   128'(bus.AXI_wen_o), 128'd0);

        // Single line in, single line out.
        wr(32'h24687571, D1);
        check("t1_state", 128'(bus.state_o), 128'(WB_WORKING));
        check("t1_wen",   128'(bus.AXI_wen_o), 128'd1);
        check("t1_waddr", 128'(bus.AXI_waddr_o), 128'h24687570);
        check("t1_wdata", bus.AXI_wdata_o, D1);
        ack();
        check("t1_pop_state", 128'(bus.state_o), 128'(WB_EMPTY));
        check("t1_pop_wen",   128'(bus.AXI_wen_o), 128'd0);

        // Four distinct lines, then read miss and read hit.
        wr(32'h24687571, DA);
        wr(32'h24697571, DB);
        wr(32'h25687571, DA);
        wr(32'h24617571, DA);
        check("t2_whit",  128'(bus.whit_o), 128'd0);
        check("t2_state", 128'(bus.state_o), 128'(WB_WORKING));
        check("t2_head",  128'(bus.AXI_waddr_o), 128'h24687570);
        rd(32'h99617570);
        check("t2_miss_rhit",  128'(bus.rhit_o), 128'd0);
        check("t2_miss_rdata", bus.rdata_o, 128'd0);
        rd(32'h24617570);
        check("t2_hit_rhit",  128'(bus.rhit_o), 128'd1);
        check("t2_hit_rdata", bus.rdata_o, DA);

        // Fill to full, drop an extra write, pop the oldest.
        wr(32'h24387571, DA);
        wr(32'h24307571, DA);
        wr(32'h14387571, DA);
        check("t3_seven_state", 128'(bus.state_o), 128'(WB_WORKING));
        wr(32'h74387571, DA);
        check("t3_full_state", 128'(bus.state_o), 128'(WB_FULL));
        wr(32'h55555570, DB);
        check("t3_drop_whit",  128'(bus.whit_o), 128'd0);
        check("t3_drop_state", 128'(bus.state_o), 128'(WB_FULL));
        ack();
        check("t3_pop_state", 128'(bus.state_o), 128'(WB_WORKING));
        check("t3_pop_waddr", 128'(bus.AXI_waddr_o), 128'h24697570);
        check("t3_pop_wdata", bus.AXI_wdata_o, DB);
        rd(32'h24687570);
        check("t3_popped_rhit", 128'(bus.rhit_o), 128'd0);
        rd(32'h55555570);
        check("t3_dropped_rhit", 128'(bus.rhit_o), 128'd0);

        // Merge into an existing line.
        wr(32'h24617573, 128'h0);
        check("t4_whit",  128'(bus.whit_o), 128'd1);
        check("t4_state", 128'(bus.state_o), 128'(WB_WORKING));
        rd(32'h24697570);
        check("t4_rhit",  128'(bus.rhit_o), 128'd1);
        check("t4_rdata", bus.rdata_o, DB);
        rd(32'h24617570);
        check("t4_merged_rhit",  128'(bus.rhit_o), 128'd1);
        check("t4_merged_rdata", bus.rdata_o, 128'd0);

        // Merge into head together with a response: head kept and re-issued.
        cycle(1'b1, 32'h2469757b, 128'h1111, 1'b0, 32'h0, 1'b1);
        check("t5_whit",  128'(bus.whit_o), 128'd1);
        check("t5_state", 128'(bus.state_o), 128'(WB_WORKING));
        check("t5_waddr", 128'(bus.AXI_waddr_o), 128'h24697570);
        check("t5_wdata", bus.AXI_wdata_o, 128'h1111);

        // Push and pop in the same cycle while full.
        wr(32'h66666660, DB);
        check("t7_full_state", 128'(bus.state_o), 128'(WB_FULL));
        cycle(1'b1, 32'h77777770, 128'h7777, 1'b0, 32'h0, 1'b1);
        check("t7_pp_state", 128'(bus.state_o), 128'(WB_FULL));
        check("t7_pp_waddr", 128'(bus.AXI_waddr_o), 128'h25687570);
        check("t7_pp_wdata", bus.AXI_wdata_o, DA);
        rd(32'h24697570);
        check("t7_popped_rhit", 128'(bus.rhit_o), 128'd0);
        rd(32'h77777770);
        check("t7_new_rhit",  128'(bus.rhit_o), 128'd1);
        check("t7_new_rdata", bus.rdata_o, 128'h7777);

        // Asynchronous reset with lines queued.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_state", 128'(bus.state_o), 128'(WB_EMPTY));
        check("t6_wen",   128'(bus.AXI_wen_o), 128'd0);
        check("t6_waddr", 128'(bus.AXI_waddr_o), 128'd0);
        check("t6_rhit",  128'(bus.rhit_o), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        rd(32'h25687570);
        check("t6_read_rhit",  128'(bus.rhit_o), 128'd0);
        check("t6_read_rdata", bus.rdata_o, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
